binary_linear_weight_streamer: RTL and testbench

// Transmit side of the binary linear layer's weight port: holds one layer's transposed,

---
 rtl/binary_linear_weight_streamer_if.sv | 11 +
 rtl/binary_linear_weight_streamer.sv | 142 ++++++++++++++
 tb/tb_binary_linear_weight_streamer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_linear_weight_streamer_if.sv
// rtl/binary_linear_weight_streamer_if.sv - valid/ready beat channel for weight load and stream ports
interface binary_linear_weight_streamer_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/binary_linear_weight_streamer.sv
// rtl/binary_linear_weight_streamer.sv - stores one layer of binary weight beats and replays them
// in order, a requested number of passes per start, over a registered valid/ready output.
module binary_linear_weight_streamer #(
  parameter int WEIGHT_WIDTH = 1,
  parameter int IN_SIZE      = 4,
  parameter int PARALLELISM  = 2,
  parameter int IN_DEPTH     = 3,
  parameter int OUT_BLOCKS   = 2,
  parameter int PASS_WIDTH   = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  binary_linear_weight_streamer_if.slave         load,
  binary_linear_weight_streamer_if.master        weight,
  input  logic                                   start,
  input  logic [PASS_WIDTH-1:0]                  passes,
  input  logic                                   reload,
  output logic                                   busy,
  output logic                                   done
);

  localparam int WEIGHT_SIZE = IN_SIZE * PARALLELISM;
  localparam int DEPTH       = IN_DEPTH * OUT_BLOCKS;
  localparam int BEAT_W      = WEIGHT_WIDTH * WEIGHT_SIZE;
  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_READY,
    S_STREAM
  } state_t;

  state_t                state;
  logic [BEAT_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_next;
  logic [PASS_WIDTH-1:0] pass_cnt;
  logic [PASS_WIDTH-1:0] pass_last;
  logic [BEAT_W-1:0]     weight_q;
  logic                  weight_valid_q;
  logic                  load_ready_q;
  logic                  load_fire;
  logic                  beat_fire;
  logic                  last_beat;

  assign load.ready   = load_ready_q;
  assign weight.data  = weight_q;
  assign weight.valid = weight_valid_q;

  assign load_fire = load.valid && load_ready_q;
  assign beat_fire = weight_valid_q && weight.ready;
  assign rd_next   = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  assign last_beat = (rd_ptr == LAST) && (pass_cnt == pass_last);

  // Storage is deliberately left out of reset; contents are only trusted after a full load.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= load.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_EMPTY;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pass_cnt       <= '0;
      pass_last      <= '0;
      weight_q       <= '0;
      weight_valid_q <= 1'b0;
      load_ready_q   <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (load_fire) begin
            if (wr_ptr == LAST) begin
              wr_ptr       <= '0;
              load_ready_q <= 1'b0;
              state        <= S_READY;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end

        S_READY: begin
          // start outranks reload when both arrive together
          if (start) begin
            if (passes != '0) begin
              state          <= S_STREAM;
              busy           <= 1'b1;
              rd_ptr         <= '0;
              pass_cnt       <= '0;
              pass_last      <= passes - 1'b1;
              weight_q       <= mem[0];
              weight_valid_q <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (reload) begin
            state        <= S_EMPTY;
            wr_ptr       <= '0;
            load_ready_q <= 1'b1;
          end
        end

        S_STREAM: begin
          // rd_ptr tracks the beat currently held in weight_q; it only moves on a handshake
          if (beat_fire) begin
            if (last_beat) begin
              state          <= S_READY;
              busy           <= 1'b0;
              done           <= 1'b1;
              weight_valid_q <= 1'b0;
              rd_ptr         <= '0;
              pass_cnt       <= '0;
            end else begin
              rd_ptr   <= rd_next;
              weight_q <= mem[rd_next];
              if (rd_ptr == LAST) begin
                pass_cnt <= pass_cnt + 1'b1;
              end
            end
          end
        end

        default: begin
          state          <= S_EMPTY;
          weight_valid_q <= 1'b0;
          busy           <= 1'b0;
          load_ready_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_linear_weight_streamer.sv
// tb/tb_binary_linear_weight_streamer.sv - scoreboard bench for binary_linear_weight_streamer
module tb_binary_linear_weight_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] passes;
  logic        reload;
  logic        busy;
  logic        done;
  logic        rand_mode;

  int vectors;
  int miscompares;
  int done_cnt;

  logic [7:0] exp_q [$];

  binary_linear_weight_streamer_if #(.W(8)) lif ();
  binary_linear_weight_streamer_if #(.W(8)) wif ();

  binary_linear_weight_streamer #(
    .WEIGHT_WIDTH(1),
    .IN_SIZE(4),
    .PARALLELISM(2),
    .IN_DEPTH(3),
    .OUT_BLOCKS(2),
    .PASS_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(lif),
    .weight(wif),
    .start(start),
    .passes(passes),
    .reload(reload),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push6(input logic [7:0] base);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(base + i));
  endtask

  task automatic load6(input logic [7:0] base);
    for (int i = 0; i < 6; i++) begin
      lif.valid = 1'b1;
      lif.data  = 8'(base + i);
      tick();
    end
    lif.valid = 1'b0;
  endtask

  task automatic issue_start(input int p, input logic rl);
    start  = 1'b1;
    passes = 16'(p);
    reload = rl;
    tick();
    start  = 1'b0;
    reload = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  // consumer back-pressure
  initial begin
    wif.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wif.ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops the scoreboard on every handshake and checks the hold rule on stalls
  initial begin
    logic       stall;
    logic [7:0] held;
    logic [7:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", {31'd0, wif.valid}, 32'd1);
          check("hold_data", {24'd0, wif.data}, {24'd0, held});
        end
        if (done) done_cnt++;
        if (wif.valid && wif.ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_beat: got %0h expected none", wif.data);
          end else begin
            e = exp_q.pop_front();
            check("beat", {24'd0, wif.data}, {24'd0, e});
          end
        end
        stall = wif.valid && !wif.ready;
        held  = wif.data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int d0;
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    rand_mode   = 1'b0;
    rst         = 1'b0;
    start       = 1'b0;
    passes      = '0;
    reload      = 1'b0;
    lif.valid   = 1'b0;
    lif.data    = '0;
    repeat (3) tick();
    rst = 1'b1;
    check("rst_valid", {31'd0, wif.valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_load_ready", {31'd0, lif.ready}, 32'd1);
    check("rst_weight", {24'd0, wif.data}, 32'd0);

    // 1: back-to-back load, single pass at full rate
    load6(8'h01);
    check("t1_load_ready_low", {31'd0, lif.ready}, 32'd0);
    push6(8'h01);
    d0 = done_cnt;
    issue_start(1, 1'b0);
    check("t1_latency_valid", {31'd0, wif.valid}, 32'd1);
    check("t1_first_beat", {24'd0, wif.data}, 32'h01);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(100, c);
    check("t1_cycles", c, 6);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);
    check("t1_valid_drop", {31'd0, wif.valid}, 32'd0);
    check("t1_load_ready", {31'd0, lif.ready}, 32'd0);
    check("t1_drained", exp_q.size(), 0);
    tick();
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_done_clear", {31'd0, done}, 32'd0);

    // 2: three passes with random back-pressure
    rand_mode = 1'b1;
    push6(8'h01); push6(8'h01); push6(8'h01);
    d0 = done_cnt;
    issue_start(3, 1'b0);
    wait_done(1000, c);
    check("t2_drained", exp_q.size(), 0);
    tick();
    check("t2_done_once", done_cnt - d0, 1);
    rand_mode = 1'b0;
    tick();

    // 3: reload, gapped load, start ignored while EMPTY, extra loads ignored
    pulse_reload();
    check("t3_load_ready", {31'd0, lif.ready}, 32'd1);
    start  = 1'b1;
    passes = 16'd1;
    tick();
    start = 1'b0;
    tick();
    check("t3_empty_start_valid", {31'd0, wif.valid}, 32'd0);
    check("t3_empty_start_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      lif.valid = 1'b1;
      lif.data  = 8'(8'h01 + i);
      tick();
      lif.valid = 1'b0;
      tick();
      tick();
      if (i == 4) check("t3_partial_ready", {31'd0, lif.ready}, 32'd1);
    end
    check("t3_full", {31'd0, lif.ready}, 32'd0);
    lif.valid = 1'b1;
    lif.data  = 8'hEE;
    tick();
    tick();
    lif.valid = 1'b0;
    push6(8'h01);
    d0 = done_cnt;
    issue_start(1, 1'b0);
    wait_done(100, c);
    check("t3_cycles", c, 6);
    check("t3_drained", exp_q.size(), 0);
    tick();
    check("t3_done_once", done_cnt - d0, 1);

    // 4: zero passes, then start with reload in the same cycle
    d0 = done_cnt;
    issue_start(0, 1'b0);
    check("t4_zero_done", {31'd0, done}, 32'd1);
    check("t4_zero_valid", {31'd0, wif.valid}, 32'd0);
    check("t4_zero_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t4_zero_done_clear", {31'd0, done}, 32'd0);
    check("t4_zero_done_once", done_cnt - d0, 1);
    push6(8'h01);
    issue_start(1, 1'b1);
    check("t4_start_wins", {31'd0, wif.valid}, 32'd1);
    wait_done(100, c);
    check("t4_drained", exp_q.size(), 0);
    tick();

    // 5: reset after the 4th beat of pass 2, then a fresh load
    push6(8'h01);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h01 + i));
    d0 = done_cnt;
    issue_start(2, 1'b0);
    repeat (10) tick();
    rst = 1'b0;
    #1;
    check("t5_valid", {31'd0, wif.valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_load_ready", {31'd0, lif.ready}, 32'd1);
    check("t5_beats_seen", exp_q.size(), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t5_no_done", done_cnt - d0, 0);
    load6(8'hA1);
    push6(8'hA1);
    issue_start(1, 1'b0);
    wait_done(100, c);
    check("t5_drained", exp_q.size(), 0);
    tick();

    // 6: reload and replace contents, two passes
    pulse_reload();
    load6(8'hF0);
    push6(8'hF0); push6(8'hF0);
    d0 = done_cnt;
    issue_start(2, 1'b0);
    wait_done(100, c);
    check("t6_cycles", c, 12);
    check("t6_drained", exp_q.size(), 0);
    tick();
    check("t6_done_once", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
